// File: rtl/integral_image_gen.sv
// Streaming integral-image generator: raster 8-bit pixels in, inclusive I(x,y) out, one line buffer.
// Optional sticky carry-out detection is compiled in with INTEGRAL_OVF_EN.
module integral_image_gen #(
  parameter int PIX_W = 8,
  parameter int OUT_W = 32,
  parameter int MAX_W = 1024,
  parameter int DIM_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [DIM_W-1:0] cfg_width,
  input  logic [DIM_W-1:0] cfg_height,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic [PIX_W-1:0] pix_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             cfg_err,
  output logic             ovf
);
  localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;

  logic [DIM_W-1:0] w_q, h_q, x, y;
  logic [OUT_W-1:0] row_sum;
  logic [OUT_W-1:0] lb [MAX_W];
  logic             cfg_ok, accept, out_fire, x_end, y_end;
  logic [OUT_W-1:0] pix_ext, l_val, r_nxt, i_nxt;

  assign cfg_ok    = (cfg_width != '0) && (32'(cfg_width) <= MAX_W) && (cfg_height != '0);
  assign pix_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept    = pix_valid && pix_ready;
  assign out_fire  = out_valid && out_ready;
  assign x_end     = (x == w_q - DIM_W'(1));
  assign y_end     = (y == h_q - DIM_W'(1));
  assign busy      = (state != IDLE);
  assign pix_ext   = OUT_W'(pix_data);
  // First row has no row above; the buffer still holds the previous frame there.
  assign l_val     = (y == '0) ? '0 : lb[x[AW-1:0]];

`ifdef INTEGRAL_OVF_EN
  logic [OUT_W:0] r_sum, i_sum;
  logic           ovf_q;
  assign r_sum = {1'b0, row_sum} + {1'b0, pix_ext};
  assign i_sum = {1'b0, r_sum[OUT_W-1:0]} + {1'b0, l_val};
  assign r_nxt = r_sum[OUT_W-1:0];
  assign i_nxt = i_sum[OUT_W-1:0];
  assign ovf   = ovf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                  ovf_q <= 1'b0;
    else if (state == IDLE && start && cfg_ok)  ovf_q <= 1'b0;
    else if (accept && (r_sum[OUT_W] || i_sum[OUT_W])) ovf_q <= 1'b1;
  end
`else
  assign r_nxt = row_sum + pix_ext;
  assign i_nxt = r_nxt + l_val;
  assign ovf   = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start && cfg_ok) state_nxt = RUN;
      RUN:     if (accept && x_end && y_end) state_nxt = DRAIN;
      DRAIN:   if (out_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_q       <= '0;
      h_q       <= '0;
      x         <= '0;
      y         <= '0;
      row_sum   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      done    <= 1'b0;
      cfg_err <= 1'b0;
      if (state == IDLE && start) begin
        if (cfg_ok) begin
          w_q     <= cfg_width;
          h_q     <= cfg_height;
          x       <= '0;
          y       <= '0;
          row_sum <= '0;
        end else begin
          cfg_err <= 1'b1;
        end
      end
      if (accept) begin
        out_data  <= i_nxt;
        out_last  <= x_end && y_end;
        out_valid <= 1'b1;
        if (x_end) begin
          x       <= '0;
          y       <= y + DIM_W'(1);
          row_sum <= '0;
        end else begin
          x       <= x + DIM_W'(1);
          row_sum <= r_nxt;
        end
      end else if (out_fire) begin
        out_valid <= 1'b0;
        // In DRAIN the only pending word is the frame's last one.
        if (state == DRAIN) begin
          done     <= 1'b1;
          out_last <= 1'b0;
        end
      end
    end
  end

  // Read-before-write: l_val above sees the old row, the write lands at the edge.
  always_ff @(posedge clk) begin
    if (accept) lb[x[AW-1:0]] <= i_nxt;
  end

endmodule

// File: tb/tb_integral_image_gen.sv
// Directed bench for integral_image_gen: scoreboard queue filled on pixel accept, drained on output accept.
module tb_integral_image_gen;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] cfg_width = '0, cfg_height = '0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic [7:0]  pix_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_last, busy, done, cfg_err, ovf;

  integral_image_gen dut (
    .clk(clk), .reset(reset), .start(start), .cfg_width(cfg_width), .cfg_height(cfg_height),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .cfg_err(cfg_err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] data; logic last; } exp_t;
  exp_t exp_q[$];
  int   errors = 0, checks = 0, done_cnt = 0;
  int   pix [64];
  int   rpat [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inclusive rectangle sum straight from the pixel array.
  function automatic logic [31:0] ref_int(input int x, input int y, input int w);
    logic [31:0] s;
    s = '0;
    for (int j = 0; j <= y; j++)
      for (int i = 0; i <= x; i++) s += 32'(pix[j*w+i]);
    return s;
  endfunction

  always @(negedge clk) begin
    if (!reset) begin
      if (done) done_cnt++;
      if (out_valid) begin
        if (exp_q.size() == 0) chk("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
        else begin
          chk("out_data", out_data, exp_q[0].data);
          chk("out_last", 32'(out_last), 32'(exp_q[0].last));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic run_frame(input int w, input int h, input int rlen, input int abort_at);
    int idx, cyc, d0;
    @(posedge clk); #1;
    start = 1'b1; cfg_width = 16'(w); cfg_height = 16'(h);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_rise", 32'(busy), 1);
    d0 = done_cnt; idx = 0; cyc = 0;
    while (idx < w*h && cyc < 4000) begin
      @(posedge clk); #1;
      out_ready = rpat[cyc % rlen][0];
      pix_valid = 1'b1;
      pix_data  = 8'(pix[idx]);
      cyc++;
      @(negedge clk);
      if (pix_ready) begin
        exp_q.push_back('{data: ref_int(idx % w, idx / w, w), last: (idx == w*h-1)});
        idx++;
        if (idx == abort_at) break;
      end
    end
    if (abort_at > 0) begin
      @(posedge clk); #1;
      pix_valid = 1'b0; reset = 1'b1;
      repeat (2) @(posedge clk);
      #1; reset = 1'b0;
      exp_q.delete();
      repeat (4) @(negedge clk);
      chk("abort_no_done", 32'(done_cnt - d0), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_out_valid", 32'(out_valid), 0);
      return;
    end
    if (rlen == 1) chk("accept_cycles", 32'(cyc), 32'(w*h));
    chk("all_pixels_in", 32'(idx), 32'(w*h));
    while (done_cnt == d0 && cyc < 4000) begin
      @(posedge clk); #1;
      pix_valid = 1'b0;
      out_ready = rpat[cyc % rlen][0];
      cyc++;
      @(negedge clk);
    end
    @(posedge clk); #1; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("done_once", 32'(done_cnt - d0), 1);
    chk("queue_empty", 32'(exp_q.size()), 0);
    chk("busy_end", 32'(busy), 0);
  endtask

  initial begin
    // reset state
    @(negedge clk);
    chk("rst_pix_ready", 32'(pix_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_cfg_err", 32'(cfg_err), 0);
    chk("rst_ovf", 32'(ovf), 0);
    @(posedge clk); #1; reset = 1'b0;

    // pixels offered in IDLE must not be consumed
    pix_valid = 1'b1; pix_data = 8'd9;
    repeat (3) begin
      @(negedge clk);
      chk("idle_pix_ready", 32'(pix_ready), 0);
      chk("idle_out_valid", 32'(out_valid), 0);
    end
    @(posedge clk); #1; pix_valid = 1'b0;

    // 4x4 all ones, full throughput
    for (int i = 0; i < 64; i++) pix[i] = 1;
    rpat[0] = 1;
    run_frame(4, 4, 1, 0);

    // 3x2 ramp 1..6
    for (int i = 0; i < 6; i++) pix[i] = i + 1;
    run_frame(3, 2, 1, 0);

    // 4x4 ones with downstream stalls
    for (int i = 0; i < 64; i++) pix[i] = 1;
    rpat[0] = 1; rpat[1] = 0; rpat[2] = 0; rpat[3] = 1;
    run_frame(4, 4, 4, 0);
    rpat[0] = 1;

    // rejected configurations
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      start = 1'b1; cfg_width = (k == 0) ? 16'd0 : 16'd1025; cfg_height = 16'd4;
      @(posedge clk); #1; start = 1'b0;
      @(negedge clk);
      chk("cfg_err_pulse", 32'(cfg_err), 1);
      chk("cfg_err_busy", 32'(busy), 0);
      chk("cfg_err_pix_ready", 32'(pix_ready), 0);
      @(negedge clk);
      chk("cfg_err_one_cycle", 32'(cfg_err), 0);
      chk("cfg_err_still_idle", 32'(busy), 0);
    end

    // 8x8 aborted by reset after 20 accepts, then 2x2 of 255
    for (int i = 0; i < 64; i++) pix[i] = (i * 7 + 3) % 256;
    run_frame(8, 8, 1, 20);
    for (int i = 0; i < 4; i++) pix[i] = 255;
    run_frame(2, 2, 1, 0);
    chk("ovf_disabled", 32'(ovf), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
